// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined execute ALU: op encoding, flag bit
// positions and the per-op architectural flag update mask.
package alu_pkg;

   typedef enum logic [2:0] {
      OP_ADD    = 3'b000,
      OP_SUB    = 3'b001,
      OP_RED    = 3'b010,
      OP_XOR    = 3'b011,
      OP_SLL    = 3'b100,
      OP_SRA    = 3'b101,
      OP_ROR    = 3'b110,
      OP_PADDSB = 3'b111
   } alu_op_e;

   localparam int FLAG_V = 0;
   localparam int FLAG_Z = 1;
   localparam int FLAG_N = 2;

   localparam logic [2:0] MASK_ALL  = 3'b111;
   localparam logic [2:0] MASK_Z    = 3'b010;
   localparam logic [2:0] MASK_NONE = 3'b000;

   // Bits of the architectural flag register a completed op may overwrite.
   function automatic logic [2:0] flag_mask(input alu_op_e op);
      logic [2:0] m;
      case (op)
         OP_ADD, OP_SUB:                 m = MASK_ALL;
         OP_XOR, OP_SLL, OP_SRA, OP_ROR: m = MASK_Z;
         OP_RED, OP_PADDSB:              m = MASK_NONE;
         default:                        m = MASK_NONE;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/alu_lane_add.sv
// Per-lane signed adders: saturated lane results for PADDSB and the raw
// LANE+1-bit lane sums that RED reduces.
module alu_lane_add
   import alu_pkg::*;
#(
   parameter int LANE  = 4,
   parameter int NLANE = 4
) (
   input  logic [LANE*NLANE-1:0]     a_i,
   input  logic [LANE*NLANE-1:0]     b_i,
   output logic [LANE*NLANE-1:0]     sat_o,
   output logic [NLANE*(LANE+1)-1:0] sum_o
);

   localparam logic [LANE-1:0] LMAX = {1'b0, {(LANE-1){1'b1}}};
   localparam logic [LANE-1:0] LMIN = {1'b1, {(LANE-1){1'b0}}};

   for (genvar g = 0; g < NLANE; g++) begin : g_lane
      logic [LANE-1:0] la_s;
      logic [LANE-1:0] lb_s;
      logic [LANE:0]   sum_s;
      logic [LANE-1:0] sat_s;

      assign la_s  = a_i[g*LANE +: LANE];
      assign lb_s  = b_i[g*LANE +: LANE];
      assign sum_s = {la_s[LANE-1], la_s} + {lb_s[LANE-1], lb_s};

      // Clamp the lane when the sign of the extended sum disagrees with its top bit.
      always_comb begin
         sat_s = sum_s[LANE-1:0];
         if (sum_s[LANE] != sum_s[LANE-1]) begin
            sat_s = sum_s[LANE] ? LMIN : LMAX;
         end else begin
            sat_s = sum_s[LANE-1:0];
         end
      end

      assign sat_o[g*LANE +: LANE]         = sat_s;
      assign sum_o[g*(LANE+1) +: (LANE+1)] = sum_s;
   end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage execute ALU with valid/ready handshake, flush and an
// architectural {N,Z,V} flag register updated on output handshake.
module alu_pipe
   import alu_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int LANE  = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       ctl,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [2:0]       flags,
   output logic [2:0]       flags_q
);

   localparam int NLANE = WIDTH / LANE;
   localparam int SHW   = $clog2(WIDTH);

   localparam logic [WIDTH-1:0] SMAX  = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] SMIN  = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [SHW:0]     W_AMT = (SHW+1)'(WIDTH);

   logic             s1_valid_q, s1_valid_d;
   logic [WIDTH-1:0] s1_a_q, s1_a_d;
   logic [WIDTH-1:0] s1_b_q, s1_b_d;
   alu_op_e          s1_op_q, s1_op_d;

   logic             s2_valid_q, s2_valid_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [2:0]       flags_res_q, flags_res_d;
   logic [2:0]       s2_mask_q, s2_mask_d;
   logic [2:0]       arch_flags_q, arch_flags_d;

   logic adv1_s, adv2_s;

   logic [WIDTH:0]           add_raw_s;
   logic [WIDTH:0]           sub_raw_s;
   logic [WIDTH-1:0]         paddsb_s;
   logic [NLANE*(LANE+1)-1:0] lane_sum_s;
   logic [WIDTH-1:0]         red_sum_s;
   logic [SHW-1:0]           shamt_s;
   logic [SHW:0]             rot_left_s;
   logic signed [WIDTH-1:0]  sra_s;
   logic [WIDTH-1:0]         res_s;
   logic                     v_s;
   logic [2:0]               flg_s;

   assign adv2_s   = ~s2_valid_q | out_ready;
   assign adv1_s   = ~s1_valid_q | adv2_s;
   assign in_ready = adv1_s & ~flush;

   assign out_valid = s2_valid_q;
   assign result    = result_q;
   assign flags     = flags_res_q;
   assign flags_q   = arch_flags_q;

   // Stage-1 arithmetic, computed from the operand latch.
   assign add_raw_s  = {s1_a_q[WIDTH-1], s1_a_q} + {s1_b_q[WIDTH-1], s1_b_q};
   assign sub_raw_s  = {s1_a_q[WIDTH-1], s1_a_q} - {s1_b_q[WIDTH-1], s1_b_q};
   assign shamt_s    = s1_b_q[SHW-1:0];
   assign rot_left_s = W_AMT - {1'b0, shamt_s};
   assign sra_s      = $signed(s1_a_q) >>> shamt_s;

   alu_lane_add #(
      .LANE  (LANE),
      .NLANE (NLANE)
   ) u_lane_add (
      .a_i   (s1_a_q),
      .b_i   (s1_b_q),
      .sat_o (paddsb_s),
      .sum_o (lane_sum_s)
   );

   // Reduce the sign-extended lane sums into one WIDTH-bit total.
   always_comb begin
      red_sum_s = '0;
      for (int i = 0; i < NLANE; i++) begin
         red_sum_s = red_sum_s + WIDTH'($signed(lane_sum_s[i*(LANE+1) +: (LANE+1)]));
      end
   end

   // Result select and overflow; a zero rotate shifts left by WIDTH, which yields 0.
   always_comb begin
      res_s = '0;
      v_s   = 1'b0;
      case (s1_op_q)
         OP_ADD: begin
            if (add_raw_s[WIDTH] != add_raw_s[WIDTH-1]) begin
               res_s = add_raw_s[WIDTH] ? SMIN : SMAX;
               v_s   = 1'b1;
            end else begin
               res_s = add_raw_s[WIDTH-1:0];
               v_s   = 1'b0;
            end
         end
         OP_SUB: begin
            if (sub_raw_s[WIDTH] != sub_raw_s[WIDTH-1]) begin
               res_s = sub_raw_s[WIDTH] ? SMIN : SMAX;
               v_s   = 1'b1;
            end else begin
               res_s = sub_raw_s[WIDTH-1:0];
               v_s   = 1'b0;
            end
         end
         OP_RED:    res_s = red_sum_s;
         OP_XOR:    res_s = s1_a_q ^ s1_b_q;
         OP_SLL:    res_s = s1_a_q << shamt_s;
         OP_SRA:    res_s = sra_s;
         OP_ROR:    res_s = (s1_a_q >> shamt_s) | (s1_a_q << rot_left_s);
         OP_PADDSB: res_s = paddsb_s;
         default: begin
            res_s = '0;
            v_s   = 1'b0;
         end
      endcase
   end

   // Per-result flags in {N,Z,V} order.
   always_comb begin
      flg_s         = 3'b000;
      flg_s[FLAG_N] = res_s[WIDTH-1];
      flg_s[FLAG_Z] = (res_s == '0);
      flg_s[FLAG_V] = v_s;
   end

   // Stage-1 next state: flush empties, otherwise load on accept or hold under stall.
   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_a_d     = s1_a_q;
      s1_b_d     = s1_b_q;
      s1_op_d    = s1_op_q;
      if (flush) begin
         s1_valid_d = 1'b0;
      end else if (adv1_s) begin
         s1_valid_d = in_valid;
         if (in_valid) begin
            s1_a_d  = a;
            s1_b_d  = b;
            s1_op_d = alu_op_e'(ctl);
         end else begin
            s1_a_d  = s1_a_q;
            s1_b_d  = s1_b_q;
            s1_op_d = s1_op_q;
         end
      end else begin
         s1_valid_d = s1_valid_q;
      end
   end

   // Stage-2 next state: capture the computed result when stage 1 moves forward.
   always_comb begin
      s2_valid_d  = s2_valid_q;
      result_d    = result_q;
      flags_res_d = flags_res_q;
      s2_mask_d   = s2_mask_q;
      if (flush) begin
         s2_valid_d = 1'b0;
      end else if (adv2_s) begin
         s2_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            result_d    = res_s;
            flags_res_d = flg_s;
            s2_mask_d   = flag_mask(s1_op_q);
         end else begin
            result_d    = result_q;
            flags_res_d = flags_res_q;
            s2_mask_d   = s2_mask_q;
         end
      end else begin
         s2_valid_d = s2_valid_q;
      end
   end

   // Architectural flags merge only on a real (non-flushed) output handshake.
   always_comb begin
      arch_flags_d = arch_flags_q;
      if (s2_valid_q && out_ready && !flush) begin
         arch_flags_d = (arch_flags_q & ~s2_mask_q) | (flags_res_q & s2_mask_q);
      end else begin
         arch_flags_d = arch_flags_q;
      end
   end

   // Pipeline and flag registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q   <= 1'b0;
         s1_a_q       <= '0;
         s1_b_q       <= '0;
         s1_op_q      <= OP_ADD;
         s2_valid_q   <= 1'b0;
         result_q     <= '0;
         flags_res_q  <= 3'b000;
         s2_mask_q    <= 3'b000;
         arch_flags_q <= 3'b000;
      end else begin
         s1_valid_q   <= s1_valid_d;
         s1_a_q       <= s1_a_d;
         s1_b_q       <= s1_b_d;
         s1_op_q      <= s1_op_d;
         s2_valid_q   <= s2_valid_d;
         result_q     <= result_d;
         flags_res_q  <= flags_res_d;
         s2_mask_q    <= s2_mask_d;
         arch_flags_q <= arch_flags_d;
      end
   end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe (WIDTH=16, LANE=4): vector table plus
// backpressure, flush and asynchronous reset sequences.
module tb_alu_pipe;
   import alu_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] a;
   logic [15:0] b;
   logic [2:0]  ctl;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] result;
   logic [2:0]  flags;
   logic [2:0]  flags_q;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      alu_op_e     op;
      logic [15:0] res;
      logic [2:0]  fl;
      logic [2:0]  fq;
   } vec_t;

   vec_t vecs[22];

   alu_pipe #(.WIDTH(16), .LANE(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .ctl       (ctl),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .flags     (flags),
      .flags_q   (flags_q)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // One op through an otherwise idle pipe with out_ready high.
   task automatic run_op(input string id, input logic [15:0] ta, input logic [15:0] tbv,
                         input alu_op_e op, input logic [15:0] er, input logic [2:0] ef,
                         input logic [2:0] efq);
      @(negedge clk);
      a = ta; b = tbv; ctl = op; in_valid = 1'b1; out_ready = 1'b1;
      #1 chk({id, "_in_ready"}, 32'(in_ready), 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      chk({id, "_early_valid"}, 32'(out_valid), 32'd0);
      @(negedge clk);
      chk({id, "_out_valid"}, 32'(out_valid), 32'd1);
      chk({id, "_result"}, 32'(result), 32'(er));
      chk({id, "_flags"}, 32'(flags), 32'(ef));
      @(negedge clk);
      chk({id, "_flags_q"}, 32'(flags_q), 32'(efq));
      chk({id, "_drained"}, 32'(out_valid), 32'd0);
   endtask

   logic [15:0] bp_a[4];
   logic [15:0] bp_exp[4];
   logic [15:0] got_res[4];
   int issued;
   int got;
   int accepts;

   initial begin
      vecs[0]  = '{16'h7000, 16'h2000, OP_ADD,    16'h7FFF, 3'b001, 3'b001};
      vecs[1]  = '{16'h8000, 16'h0001, OP_SUB,    16'h8000, 3'b101, 3'b101};
      vecs[2]  = '{16'h1234, 16'h1234, OP_XOR,    16'h0000, 3'b010, 3'b111};
      vecs[3]  = '{16'h7777, 16'h1111, OP_PADDSB, 16'h7777, 3'b000, 3'b111};
      vecs[4]  = '{16'h8888, 16'h8888, OP_PADDSB, 16'h8888, 3'b100, 3'b111};
      vecs[5]  = '{16'h1234, 16'h1111, OP_PADDSB, 16'h2345, 3'b000, 3'b111};
      vecs[6]  = '{16'h1111, 16'h1111, OP_RED,    16'h0008, 3'b000, 3'b111};
      vecs[7]  = '{16'hFFFF, 16'hFFFF, OP_RED,    16'hFFF8, 3'b100, 3'b111};
      vecs[8]  = '{16'h1234, 16'h0004, OP_ROR,    16'h4123, 3'b000, 3'b101};
      vecs[9]  = '{16'h8000, 16'h0003, OP_SRA,    16'hF000, 3'b100, 3'b101};
      vecs[10] = '{16'h0001, 16'h000F, OP_SLL,    16'h8000, 3'b100, 3'b101};
      vecs[11] = '{16'h1234, 16'h0000, OP_ROR,    16'h1234, 3'b000, 3'b101};
      vecs[12] = '{16'h0001, 16'h0002, OP_ADD,    16'h0003, 3'b000, 3'b000};
      vecs[13] = '{16'h0005, 16'h0005, OP_SUB,    16'h0000, 3'b010, 3'b010};
      vecs[14] = '{16'h8000, 16'hFFFF, OP_ADD,    16'h8000, 3'b101, 3'b101};
      vecs[15] = '{16'h00FF, 16'h0014, OP_SLL,    16'h0FF0, 3'b000, 3'b101};
      vecs[16] = '{16'h7000, 16'h0004, OP_SRA,    16'h0700, 3'b000, 3'b101};
      vecs[17] = '{16'hFFFF, 16'h0F0F, OP_XOR,    16'hF0F0, 3'b100, 3'b101};
      vecs[18] = '{16'h0001, 16'h0001, OP_ROR,    16'h8000, 3'b100, 3'b101};
      vecs[19] = '{16'h7FFF, 16'hFFFF, OP_SUB,    16'h7FFF, 3'b001, 3'b001};
      vecs[20] = '{16'h7777, 16'h7777, OP_RED,    16'h0038, 3'b000, 3'b001};
      vecs[21] = '{16'h5555, 16'h5555, OP_XOR,    16'h0000, 3'b010, 3'b011};

      bp_a   = '{16'h0100, 16'h0200, 16'h0300, 16'h0400};
      bp_exp = '{16'h0100, 16'h0201, 16'h0302, 16'h0403};

      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      a = 16'h0000; b = 16'h0000; ctl = 3'b000;

      // Reset state.
      @(posedge clk); @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_result", 32'(result), 32'd0);
      chk("rst_flags", 32'(flags), 32'd0);
      chk("rst_flags_q", 32'(flags_q), 32'd0);
      rst_n = 1'b1;
      #1 chk("rst_in_ready", 32'(in_ready), 32'd1);

      for (int i = 0; i < 22; i++) begin
         run_op($sformatf("v%0d", i), vecs[i].a, vecs[i].b, vecs[i].op,
                vecs[i].res, vecs[i].fl, vecs[i].fq);
      end

      // Backpressure: consumer stalled, only two ops fit.
      issued = 0; accepts = 0; got = 0;
      for (int cyc = 0; cyc < 4; cyc++) begin
         @(negedge clk);
         out_ready = 1'b0;
         in_valid = 1'b1; a = bp_a[issued]; b = 16'(issued); ctl = OP_ADD;
         #1;
         if (in_ready) begin
            issued++;
            accepts++;
         end
      end
      chk("bp_accepts", 32'(accepts), 32'd2);
      chk("bp_in_ready_low", 32'(in_ready), 32'd0);
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_result", 32'(result), 32'(bp_exp[0]));
      for (int cyc = 0; cyc < 20 && got < 4; cyc++) begin
         @(negedge clk);
         out_ready = 1'b1;
         if (issued < 4) begin
            in_valid = 1'b1; a = bp_a[issued]; b = 16'(issued); ctl = OP_ADD;
         end else begin
            in_valid = 1'b0;
         end
         #1;
         if (out_valid) begin
            got_res[got] = result;
            got++;
         end
         if (in_valid && in_ready) issued++;
      end
      chk("bp_count", 32'(got), 32'd4);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("bp_order%0d", i), 32'(got_res[i]), 32'(bp_exp[i]));
      end
      in_valid = 1'b0;
      for (int cyc = 0; cyc < 3; cyc++) begin
         @(negedge clk);
         chk($sformatf("bp_no_dup%0d", cyc), 32'(out_valid), 32'd0);
      end
      chk("bp_flags_q", 32'(flags_q), 32'd0);

      // Flush with two ops in flight.
      @(negedge clk);
      out_ready = 1'b0; in_valid = 1'b1; a = 16'h8000; b = 16'h8000; ctl = OP_ADD;
      @(negedge clk);
      a = 16'h8000; b = 16'hFFFF;
      @(negedge clk);
      flush = 1'b1; a = 16'h7000; b = 16'h2000;
      #1 chk("fl_in_ready", 32'(in_ready), 32'd0);
      chk("fl_pre_valid", 32'(out_valid), 32'd1);
      @(negedge clk);
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      #1 chk("fl_out_valid", 32'(out_valid), 32'd0);
      @(negedge clk);
      chk("fl_s1_cleared", 32'(out_valid), 32'd0);
      @(negedge clk);
      chk("fl_no_late", 32'(out_valid), 32'd0);
      chk("fl_flags_q", 32'(flags_q), 32'd0);
      run_op("fl_recover", 16'h0001, 16'h0001, OP_ADD, 16'h0002, 3'b000, 3'b000);

      // Asynchronous reset in the middle of a stall.
      run_op("rs_pre", 16'h8000, 16'h0001, OP_SUB, 16'h8000, 3'b101, 3'b101);
      @(negedge clk);
      out_ready = 1'b0; in_valid = 1'b1; a = 16'h7000; b = 16'h2000; ctl = OP_ADD;
      @(negedge clk);
      a = 16'h0001; b = 16'h0002;
      @(negedge clk);
      in_valid = 1'b0;
      chk("rs_stall_valid", 32'(out_valid), 32'd1);
      chk("rs_stall_result", 32'(result), 32'h7FFF);
      chk("rs_stall_flags", 32'(flags), 32'd1);
      chk("rs_stall_flags_q", 32'(flags_q), 32'h5);
      #2 rst_n = 1'b0;
      #1;
      chk("rs_async_valid", 32'(out_valid), 32'd0);
      chk("rs_async_result", 32'(result), 32'd0);
      chk("rs_async_flags", 32'(flags), 32'd0);
      chk("rs_async_flags_q", 32'(flags_q), 32'd0);
      @(negedge clk);
      rst_n = 1'b1; out_ready = 1'b1;
      #1 chk("rs_in_ready", 32'(in_ready), 32'd1);
      for (int cyc = 0; cyc < 3; cyc++) begin
         @(negedge clk);
         chk($sformatf("rs_discard%0d", cyc), 32'(out_valid), 32'd0);
      end
      run_op("rs_recover", 16'h0000, 16'h0003, OP_SLL, 16'h0000, 3'b010, 3'b010);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
Parametrised, two-stage pipelined successor to the 16-bit single-cycle execute ALU.
- Keeps the 3-bit op encoding and the saturating/packed semantics.
- Generalises data width and packed-lane width, and makes ROR a full variable rotate.
- Adds valid/ready handshake with backpressure, a pipeline flush, and an architectural flag register with per-op update masks.
- Sits in EX between ID/EX operand latch and EX/MEM; stalls propagate back through in_ready.

Parameters:
WIDTH, 16, datapath width; power of 2, >= 8.
LANE, 4, packed-lane width for RED/PADDSB; WIDTH % LANE == 0.
(localparams: NLANE = WIDTH/LANE; SHW = $clog2(WIDTH))

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous; drops all in-flight ops
in_valid  in  1  operand/op presented
in_ready  out  1  pipeline can accept this cycle
a  in  WIDTH  operand A (signed)
b  in  WIDTH  operand B (signed)
ctl  in  3  op: 000 ADD, 001 SUB, 010 RED, 011 XOR, 100 SLL, 101 SRA, 110 ROR, 111 PADDSB
out_valid  out  1  result available
out_ready  in  1  consumer accepts result
result  out  WIDTH  op result
flags  out  3  per-result {N,Z,V}, aligned with result
flags_q  out  3  architectural {N,Z,V}, updated on output handshake

Behaviour:
- Reset (async, rst_n=0):
  - s1_valid=0, s2_valid=0, out_valid=0.
  - result=0, flags=0, flags_q=0.
  - in_ready=1 after release.
  - Reset mid-operation discards all in-flight ops.
- Stage 1 registers a, b, ctl and computes:
  - raw add/sub (WIDTH+1 bits);
  - lane sums (LANE+1 bits each);
  - shift amount b[SHW-1:0].
- Stage 2 registers the final result and flags; result/flags are driven directly from stage-2 flops.
- Handshake:
  - adv2 = !s2_valid | out_ready.
  - adv1 = !s1_valid | adv2.
  - in_ready = adv1 & !flush.
  - Accept = in_valid & in_ready.
- Latency 2 cycles, accept to out_valid, with out_ready held high. Throughput 1 op/cycle.
- Under out_ready=0, up to 2 ops are held; order is preserved, none dropped or duplicated.
- flush: clears s1_valid and s2_valid at the next edge; no accept that cycle (flush wins over in_valid); flags_q is not updated by flushed ops.
- ADD/SUB: signed, saturating to 2^(W-1)-1 / -2^(W-1). V=1 iff saturated.
- RED:
  - Each lane a_i + b_i forms a signed LANE+1-bit sum, with lane operands sign-extended.
  - NLANE sums are added and sign-extended to WIDTH.
  - No saturation; V=0.
- XOR: bitwise. V=0.
- SLL: logical left by b[SHW-1:0]. SRA: arithmetic right by b[SHW-1:0]. ROR: rotate right by b[SHW-1:0]; amount 0 returns a. V=0.
- PADDSB: per lane signed add, saturating to 2^(LANE-1)-1 / -2^(LANE-1). V=0.
- Flags:
  - N = result[WIDTH-1]; Z = (result == 0); V as above.
  - flags always carries all three for the current output.
- flags_q update mask, applied only on out_valid & out_ready:
  - ADD/SUB: N, Z, V.
  - XOR, SLL, SRA, ROR: Z only.
  - RED, PADDSB: none.
  - Non-updated bits retain their value.
- Simultaneous handshake on input and output in the same cycle is legal and full-rate.

Decomposition:
- Shared package alu_pkg:
  - alu_op_e enum for the 3-bit op encoding;
  - flag index constants FLAG_V=0, FLAG_Z=1, FLAG_N=2;
  - function flag_mask(op) returning the 3-bit update mask.
- One sub-module: alu_lane_add, a parametrised by LANE and NLANE generate block producing saturated PADDSB lanes and the RED lane-sum vector.

Test Plan (WIDTH=16, LANE=4):
- ADD a=0x7000 b=0x2000 -> result 0x7FFF, flags N=0 Z=0 V=1 two cycles later; flags_q=3'b001.
- SUB a=0x8000 b=0x0001 -> 0x8000, flags N=1 V=1. Then XOR a=b=0x1234 -> 0x0000; flags_q Z=1, N=1 and V=1 retained.
- PADDSB a=0x7777 b=0x1111 -> 0x7777. a=0x8888 b=0x8888 -> 0x8888. a=0x1234 b=0x1111 -> 0x2345. flags_q unchanged in all three.
- RED a=0x1111 b=0x1111 -> 0x0008. RED a=0xFFFF b=0xFFFF -> 0xFFF8. ROR a=0x1234 b=4 -> 0x4123. SRA a=0x8000 b=3 -> 0xF000. SLL a=0x0001 b=15 -> 0x8000.
- Backpressure: issue 4 back-to-back ADDs with out_ready=0 -> in_ready drops after 2 accepts. Release out_ready -> all 4 results emerge in issue order, one per cycle, none lost.
- flush with 2 ops in flight and in_valid=1 -> in_ready=0 that cycle; out_valid=0 the next cycle; flags_q unchanged. rst_n pulse mid-stall -> all outputs 0 asynchronously.
